spi_frame_reader: RTL and testbench

SPI_FRAME_READER -- requirements
Module: spi_frame_reader

---
 rtl/spi_frame_reader_pkg.sv | 36 +++
 rtl/spi_frame_reader_if.sv | 29 ++
 rtl/spi_bit_timer.sv | 34 +++
 rtl/spi_frame_reader.sv | 114 +++++++++++
 tb/tb_spi_frame_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_reader_pkg.sv
// Frame layout shared by the SPI frame reader and the frame source on the far end of the link.
package spi_frame_reader_pkg;

   localparam int FRAME_BITS = 128;

   localparam logic [7:0] START_BYTE = 8'h7E;
   localparam logic [7:0] END_BYTE   = 8'h7D;
   localparam logic [7:0] PAD_BYTE   = 8'h00;

   localparam int TRIG_HI = 119;
   localparam int TRIG_LO = 104;
   localparam int REF_HI  = 103;
   localparam int REF_LO  = 40;
   localparam int DATA_HI = 39;
   localparam int DATA_LO = 16;

   localparam int TRIG_W = TRIG_HI - TRIG_LO + 1;
   localparam int REF_W  = REF_HI - REF_LO + 1;
   localparam int DATA_W = DATA_HI - DATA_LO + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_CHECK
   } state_t;

   // A frame is malformed if its start marker, pad byte or end marker is wrong.
   function automatic logic frame_bad(input logic [FRAME_BITS-1:0] f);
      return (f[FRAME_BITS-1 -: 8] != START_BYTE) ||
             (f[15:8] != PAD_BYTE) ||
             (f[7:0] != END_BYTE);
   endfunction

endpackage

// File: rtl/spi_frame_reader_if.sv
// Request, SPI and decoded-frame signals between the frame reader and its surroundings.
interface spi_frame_reader_if
   import spi_frame_reader_pkg::*;
;
   logic              irq_n;
   logic              start;
   logic              spi_clk;
   logic              spi_cs;
   logic              spi_si;
   logic              busy;
   logic              frame_valid;
   logic              frame_err;
   logic [TRIG_W-1:0] trigger_id;
   logic [REF_W-1:0]  ref_word;
   logic [DATA_W-1:0] data;
   logic              overrun;

   modport master (
      input  irq_n, start, spi_si,
      output spi_clk, spi_cs, busy, frame_valid, frame_err,
             trigger_id, ref_word, data, overrun
   );

   modport slave (
      output irq_n, start, spi_si,
      input  spi_clk, spi_cs, busy, frame_valid, frame_err,
             trigger_id, ref_word, data, overrun
   );
endinterface

// File: rtl/spi_bit_timer.sv
// SPI bit timing: CLK_DIV cycles low then CLK_DIV cycles high per bit while enabled.
module spi_bit_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_in,
   input  logic reset,
   input  logic en,
   output logic spi_clk,
   output logic sample
);

   logic [7:0] div_cnt;
   logic       phase_hi;
   logic       phase_last;

   assign phase_last = (div_cnt == 8'(CLK_DIV - 1));

   // Half-period counter; idles low so every bit starts with a full low phase.
   always_ff @(posedge clk_in) begin
      if (reset || !en) begin
         div_cnt  <= '0;
         phase_hi <= 1'b0;
      end else if (phase_last) begin
         div_cnt  <= '0;
         phase_hi <= ~phase_hi;
      end else begin
         div_cnt  <= div_cnt + 8'd1;
      end
   end

   assign spi_clk = phase_hi;
   assign sample  = en && phase_hi && phase_last;

endmodule

// File: rtl/spi_frame_reader.sv
// Reads one 128-bit frame from an SPI mode-0 source per request and decodes its fields.
module spi_frame_reader
   import spi_frame_reader_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic               sampling_clk,
   input  logic               reset,
   spi_frame_reader_if.master bus
);

   state_t                  state;
   state_t                  state_nxt;
   logic                    irq_s1;
   logic                    irq_s2;
   logic                    irq_s3;
   logic                    irq_fall;
   logic                    req;
   logic [7:0]              ph_cnt;
   logic [6:0]              bit_cnt;
   logic [FRAME_BITS-1:0]   shreg;
   logic                    shift_en;
   logic                    sample;
   logic                    spi_clk_int;
   logic                    cs_active;

   assign irq_fall  = irq_s3 && !irq_s2;
   assign req       = bus.start || irq_fall;
   assign shift_en  = (state == ST_SHIFT);
   assign cs_active = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

   spi_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
      .clk_in  (sampling_clk),
      .reset   (reset),
      .en      (shift_en),
      .spi_clk (spi_clk_int),
      .sample  (sample)
   );

   // Two-flop synchronizer for irq_n plus one more stage to spot its falling edge.
   always_ff @(posedge sampling_clk) begin
      if (reset) begin
         irq_s1 <= 1'b1;
         irq_s2 <= 1'b1;
         irq_s3 <= 1'b1;
      end else begin
         irq_s1 <= bus.irq_n;
         irq_s2 <= irq_s1;
         irq_s3 <= irq_s2;
      end
   end

   // State register.
   always_ff @(posedge sampling_clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; a request is only taken in IDLE, start and irq merge into one.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (req) state_nxt = ST_SETUP;
         ST_SETUP: if (ph_cnt == 8'(CS_SETUP - 1)) state_nxt = ST_SHIFT;
         ST_SHIFT: if (sample && (bit_cnt == 7'(FRAME_BITS - 1))) state_nxt = ST_HOLD;
         ST_HOLD:  if (ph_cnt == 8'(CS_HOLD - 1)) state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Setup/hold cycle counter and bit counter; both restart for every phase/frame.
   always_ff @(posedge sampling_clk) begin
      if (reset || (state_nxt != state)) ph_cnt <= '0;
      else if ((state == ST_SETUP) || (state == ST_HOLD)) ph_cnt <= ph_cnt + 8'd1;

      if (reset || (state == ST_IDLE)) bit_cnt <= '0;
      else if (sample)                 bit_cnt <= bit_cnt + 7'd1;
   end

   // Shift register: first bit received ends up in the MSB after 128 samples.
   always_ff @(posedge sampling_clk) begin
      if (reset)       shreg <= '0;
      else if (sample) shreg <= {shreg[FRAME_BITS-2:0], bus.spi_si};
   end

   // Frame outputs load together with the valid strobe; overrun is sticky until reset.
   always_ff @(posedge sampling_clk) begin
      if (reset) begin
         bus.frame_valid <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.trigger_id  <= '0;
         bus.ref_word    <= '0;
         bus.data        <= '0;
         bus.overrun     <= 1'b0;
      end else begin
         bus.frame_valid <= (state == ST_CHECK);
         if (state == ST_CHECK) begin
            bus.frame_err  <= frame_bad(shreg);
            bus.trigger_id <= shreg[TRIG_HI:TRIG_LO];
            bus.ref_word   <= shreg[REF_HI:REF_LO];
            bus.data       <= shreg[DATA_HI:DATA_LO];
         end
         if (req && (state != ST_IDLE)) bus.overrun <= 1'b1;
      end
   end

   assign bus.spi_clk = spi_clk_int;
   assign bus.spi_cs  = !cs_active;
   assign bus.busy    = cs_active;

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader: default timing instance plus a fast-timing instance.
module tb_spi_frame_reader;

   logic clk = 1'b0;
   logic reset;
   logic reset2;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   spi_frame_reader_if bus ();
   spi_frame_reader_if bus2 ();

   spi_frame_reader dut (
      .sampling_clk (clk),
      .reset        (reset),
      .bus          (bus.master)
   );

   spi_frame_reader #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut2 (
      .sampling_clk (clk),
      .reset        (reset2),
      .bus          (bus2.master)
   );

   localparam logic [127:0] GOOD_FRAME =
      {8'h7E, 16'h1234, 64'h0000000000000ABC, 24'h00BEEF, 8'h00, 8'h7D};

   // Frame source models: MSB first, next bit presented after each falling spi_clk.
   logic [127:0] tx1 = GOOD_FRAME;
   logic [127:0] tx2 = GOOD_FRAME;
   logic [7:0]   idx1 = 8'd0;
   logic [7:0]   idx2 = 8'd0;

   always @(negedge bus.spi_clk or posedge bus.spi_cs) begin
      if (bus.spi_cs) idx1 = 8'd0;
      else            idx1 = idx1 + 8'd1;
   end
   always @(negedge bus2.spi_clk or posedge bus2.spi_cs) begin
      if (bus2.spi_cs) idx2 = 8'd0;
      else             idx2 = idx2 + 8'd1;
   end
   assign bus.spi_si  = idx1[7] ? 1'b0 : tx1[7'd127 - idx1[6:0]];
   assign bus2.spi_si = idx2[7] ? 1'b0 : tx2[7'd127 - idx2[6:0]];

   // Activity monitors, sampled just after each rising edge.
   int   busy_cyc = 0, rise_cnt = 0, fv_cnt = 0;
   int   busy2_cyc = 0;
   logic clk_p1 = 1'b0, clk_p2 = 1'b0, seen_hi2 = 1'b0;
   int   run2 = 1, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;

   always @(posedge clk) begin
      #1;
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.frame_valid === 1'b1) fv_cnt++;
      if ((bus.spi_clk === 1'b1) && !clk_p1) rise_cnt++;
      clk_p1 = (bus.spi_clk === 1'b1);
      if (bus2.busy === 1'b1) busy2_cyc++;
      if ((bus2.spi_clk === 1'b1) == clk_p2) run2++;
      else begin
         if (clk_p2) begin
            if (run2 < hi_min) hi_min = run2;
            if (run2 > hi_max) hi_max = run2;
         end else if (seen_hi2) begin
            if (run2 < lo_min) lo_min = run2;
            if (run2 > lo_max) lo_max = run2;
         end
         run2 = 1;
      end
      clk_p2 = (bus2.spi_clk === 1'b1);
      if (bus2.spi_cs !== 1'b0) seen_hi2 = 1'b0;
      else if (clk_p2)          seen_hi2 = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic pulse_start;
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic wait_fv(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         tick(1);
         if (bus.frame_valid === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.irq_n = 1'b1;
      tick(1);
      bus.start = 1'b1;
      tick(2);
      bus.start = 1'b0;
      tick(1);
      n_vec++; if (bus.spi_cs !== 1'b1) begin n_err++; $display("FAIL rst_spi_cs got=%b exp=1", bus.spi_cs); end
      n_vec++; if (bus.spi_clk !== 1'b0) begin n_err++; $display("FAIL rst_spi_clk got=%b exp=0", bus.spi_clk); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      n_vec++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL rst_frame_valid got=%b exp=0", bus.frame_valid); end
      n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err got=%b exp=0", bus.frame_err); end
      n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got=%b exp=0", bus.overrun); end
      n_vec++; if (bus.trigger_id !== 16'h0) begin n_err++; $display("FAIL rst_trigger_id got=%h exp=0", bus.trigger_id); end
      n_vec++; if (bus.ref_word !== 64'h0) begin n_err++; $display("FAIL rst_ref got=%h exp=0", bus.ref_word); end
      n_vec++; if (bus.data !== 24'h0) begin n_err++; $display("FAIL rst_data got=%h exp=0", bus.data); end
      reset = 1'b0;
      tick(2);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_good_frame;
      int b_busy, b_rise, b_fv;
      bit seen;
      tx1 = GOOD_FRAME;
      b_busy = busy_cyc; b_rise = rise_cnt; b_fv = fv_cnt;
      pulse_start();
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL good_busy_after_accept got=%b exp=1", bus.busy); end
      wait_fv(1200, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL good_timeout got=no_frame_valid exp=frame_valid"); end
      n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL good_err got=%b exp=0", bus.frame_err); end
      n_vec++; if (bus.trigger_id !== 16'h1234) begin n_err++; $display("FAIL good_trigger got=%h exp=1234", bus.trigger_id); end
      n_vec++; if (bus.ref_word !== 64'h0000000000000ABC) begin n_err++; $display("FAIL good_ref got=%h exp=abc", bus.ref_word); end
      n_vec++; if (bus.data !== 24'h00BEEF) begin n_err++; $display("FAIL good_data got=%h exp=00beef", bus.data); end
      tick(1);
      n_vec++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL good_fv_one_cycle got=%b exp=0", bus.frame_valid); end
      tick(20);
      n_vec++; if (bus.trigger_id !== 16'h1234) begin n_err++; $display("FAIL good_trigger_hold got=%h exp=1234", bus.trigger_id); end
      n_vec++; if (busy_cyc - b_busy != 1028) begin n_err++; $display("FAIL good_busy_cycles got=%0d exp=1028", busy_cyc - b_busy); end
      n_vec++; if (rise_cnt - b_rise != 128) begin n_err++; $display("FAIL good_spi_clk_rises got=%0d exp=128", rise_cnt - b_rise); end
      n_vec++; if (fv_cnt - b_fv != 1) begin n_err++; $display("FAIL good_fv_count got=%0d exp=1", fv_cnt - b_fv); end
   endtask

   task automatic test_frame_table;
      logic [127:0] frm  [4];
      logic [15:0]  trig [4];
      logic [63:0]  refw [4];
      logic [23:0]  dat  [4];
      logic         err  [4];
      bit seen;
      frm[0] = {8'h7E, 16'h1234, 64'h0000000000000ABC, 24'h00BEEF, 8'h00, 8'h7C};
      trig[0] = 16'h1234; refw[0] = 64'h0000000000000ABC; dat[0] = 24'h00BEEF; err[0] = 1'b1;
      frm[1] = {8'h7E, 16'hFFFF, 64'h8000000000000001, 24'hABCDEF, 8'h00, 8'h7D};
      trig[1] = 16'hFFFF; refw[1] = 64'h8000000000000001; dat[1] = 24'hABCDEF; err[1] = 1'b0;
      frm[2] = {8'h7E, 16'h0001, 64'h0123456789ABCDEF, 24'h123456, 8'h01, 8'h7D};
      trig[2] = 16'h0001; refw[2] = 64'h0123456789ABCDEF; dat[2] = 24'h123456; err[2] = 1'b1;
      frm[3] = {8'h3C, 16'hA5A5, 64'hFEDCBA9876543210, 24'h000001, 8'h00, 8'h7D};
      trig[3] = 16'hA5A5; refw[3] = 64'hFEDCBA9876543210; dat[3] = 24'h000001; err[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         apply_reset();
         tx1 = frm[k];
         pulse_start();
         wait_fv(1200, seen);
         n_vec++; if (!seen) begin n_err++; $display("FAIL tbl%0d_timeout got=no_frame_valid exp=frame_valid", k); end
         n_vec++; if (bus.frame_err !== err[k]) begin n_err++; $display("FAIL tbl%0d_err got=%b exp=%b", k, bus.frame_err, err[k]); end
         n_vec++; if (bus.trigger_id !== trig[k]) begin n_err++; $display("FAIL tbl%0d_trigger got=%h exp=%h", k, bus.trigger_id, trig[k]); end
         n_vec++; if (bus.ref_word !== refw[k]) begin n_err++; $display("FAIL tbl%0d_ref got=%h exp=%h", k, bus.ref_word, refw[k]); end
         n_vec++; if (bus.data !== dat[k]) begin n_err++; $display("FAIL tbl%0d_data got=%h exp=%h", k, bus.data, dat[k]); end
         tick(3);
      end
      tx1 = GOOD_FRAME;
   endtask

   task automatic test_irq;
      int b_busy, b_rise, b_fv;
      bit seen;
      apply_reset();
      b_busy = busy_cyc; b_rise = rise_cnt; b_fv = fv_cnt;
      bus.irq_n = 1'b0;
      wait_fv(1300, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL irq_timeout got=no_frame_valid exp=frame_valid"); end
      n_vec++; if (bus.trigger_id !== 16'h1234) begin n_err++; $display("FAIL irq_trigger got=%h exp=1234", bus.trigger_id); end
      tick(300);
      n_vec++; if (busy_cyc - b_busy != 1028) begin n_err++; $display("FAIL irq_busy_cycles got=%0d exp=1028", busy_cyc - b_busy); end
      n_vec++; if (rise_cnt - b_rise != 128) begin n_err++; $display("FAIL irq_spi_clk_rises got=%0d exp=128", rise_cnt - b_rise); end
      n_vec++; if (fv_cnt - b_fv != 1) begin n_err++; $display("FAIL irq_fv_count got=%0d exp=1", fv_cnt - b_fv); end
      bus.irq_n = 1'b1;
      tick(5);
   endtask

   task automatic test_overrun;
      int b_busy, b_fv;
      bit seen;
      apply_reset();
      b_busy = busy_cyc; b_fv = fv_cnt;
      pulse_start();
      tick(100);
      n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_before got=%b exp=0", bus.overrun); end
      pulse_start();
      n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
      wait_fv(1200, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL ovr_timeout got=no_frame_valid exp=frame_valid"); end
      tick(200);
      n_vec++; if (fv_cnt - b_fv != 1) begin n_err++; $display("FAIL ovr_fv_count got=%0d exp=1", fv_cnt - b_fv); end
      n_vec++; if (busy_cyc - b_busy != 1028) begin n_err++; $display("FAIL ovr_busy_cycles got=%0d exp=1028", busy_cyc - b_busy); end
      pulse_start();
      wait_fv(1200, seen);
      n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
      apply_reset();
      n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_cleared got=%b exp=0", bus.overrun); end
   endtask

   task automatic test_check_window;
      int  b_busy, b_fv;
      bit  seen;
      bit  got;
      apply_reset();
      b_busy = busy_cyc; b_fv = fv_cnt;
      pulse_start();
      got = 1'b0;
      for (int i = 0; i < 1200 && !got; i++) begin
         tick(1);
         if (bus.busy === 1'b0) got = 1'b1;
      end
      n_vec++; if (!got) begin n_err++; $display("FAIL chk_timeout got=busy_stuck exp=busy_low"); end
      n_vec++; if (bus.spi_cs !== 1'b1) begin n_err++; $display("FAIL chk_cs_in_check got=%b exp=1", bus.spi_cs); end
      n_vec++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL chk_fv_in_check got=%b exp=0", bus.frame_valid); end
      pulse_start();
      n_vec++; if (bus.frame_valid !== 1'b1) begin n_err++; $display("FAIL chk_fv_after_check got=%b exp=1", bus.frame_valid); end
      n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL chk_overrun got=%b exp=1", bus.overrun); end
      tick(20);
      n_vec++; if (busy_cyc - b_busy != 1028) begin n_err++; $display("FAIL chk_no_second got=%0d exp=1028", busy_cyc - b_busy); end
      apply_reset();
      pulse_start();
      wait_fv(1200, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL chk_first_timeout got=no_frame_valid exp=frame_valid"); end
      pulse_start();
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL chk_idle_accept got=%b exp=1", bus.busy); end
      n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL chk_idle_no_overrun got=%b exp=0", bus.overrun); end
      b_fv = fv_cnt;
      wait_fv(1200, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL chk_second_timeout got=no_frame_valid exp=frame_valid"); end
      tick(3);
      n_vec++; if (fv_cnt - b_fv != 1) begin n_err++; $display("FAIL chk_second_fv got=%0d exp=1", fv_cnt - b_fv); end
   endtask

   task automatic test_coincide;
      int b_busy, b_fv;
      bit seen;
      apply_reset();
      b_busy = busy_cyc; b_fv = fv_cnt;
      bus.irq_n = 1'b0;
      tick(2);
      pulse_start();
      wait_fv(1300, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL coin_timeout got=no_frame_valid exp=frame_valid"); end
      tick(300);
      n_vec++; if (fv_cnt - b_fv != 1) begin n_err++; $display("FAIL coin_fv_count got=%0d exp=1", fv_cnt - b_fv); end
      n_vec++; if (busy_cyc - b_busy != 1028) begin n_err++; $display("FAIL coin_busy_cycles got=%0d exp=1028", busy_cyc - b_busy); end
      bus.irq_n = 1'b1;
      tick(5);
   endtask

   task automatic test_reset_mid;
      int b_rise, b_fv;
      bit seen;
      bit got;
      apply_reset();
      tx1 = GOOD_FRAME;
      b_rise = rise_cnt;
      pulse_start();
      got = 1'b0;
      for (int i = 0; i < 1200 && !got; i++) begin
         tick(1);
         if (rise_cnt - b_rise == 60) got = 1'b1;
      end
      n_vec++; if (!got) begin n_err++; $display("FAIL mid_timeout got=%0d exp=60", rise_cnt - b_rise); end
      b_fv = fv_cnt;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      n_vec++; if (bus.spi_cs !== 1'b1) begin n_err++; $display("FAIL mid_cs got=%b exp=1", bus.spi_cs); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
      tick(1200);
      n_vec++; if (fv_cnt - b_fv != 0) begin n_err++; $display("FAIL mid_no_fv got=%0d exp=0", fv_cnt - b_fv); end
      pulse_start();
      wait_fv(1200, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL mid_next_timeout got=no_frame_valid exp=frame_valid"); end
      n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL mid_next_err got=%b exp=0", bus.frame_err); end
      n_vec++; if (bus.ref_word !== 64'h0000000000000ABC) begin n_err++; $display("FAIL mid_next_ref got=%h exp=abc", bus.ref_word); end
      n_vec++; if (bus.data !== 24'h00BEEF) begin n_err++; $display("FAIL mid_next_data got=%h exp=00beef", bus.data); end
   endtask

   task automatic test_fast_timing;
      int  b_busy;
      bit  seen;
      tx2 = {8'h7E, 16'hC0DE, 64'h1122334455667788, 24'h99AABB, 8'h00, 8'h7D};
      b_busy = busy2_cyc;
      bus2.start = 1'b1;
      tick(1);
      bus2.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 800 && !seen; i++) begin
         tick(1);
         if (bus2.frame_valid === 1'b1) seen = 1'b1;
      end
      n_vec++; if (!seen) begin n_err++; $display("FAIL fast_timeout got=no_frame_valid exp=frame_valid"); end
      n_vec++; if (bus2.frame_err !== 1'b0) begin n_err++; $display("FAIL fast_err got=%b exp=0", bus2.frame_err); end
      n_vec++; if (bus2.trigger_id !== 16'hC0DE) begin n_err++; $display("FAIL fast_trigger got=%h exp=c0de", bus2.trigger_id); end
      n_vec++; if (bus2.ref_word !== 64'h1122334455667788) begin n_err++; $display("FAIL fast_ref got=%h exp=1122334455667788", bus2.ref_word); end
      n_vec++; if (bus2.data !== 24'h99AABB) begin n_err++; $display("FAIL fast_data got=%h exp=99aabb", bus2.data); end
      tick(5);
      n_vec++; if (busy2_cyc - b_busy != 514) begin n_err++; $display("FAIL fast_busy_cycles got=%0d exp=514", busy2_cyc - b_busy); end
      n_vec++; if ((hi_min != 2) || (hi_max != 2)) begin n_err++; $display("FAIL fast_high_phase got=%0d..%0d exp=2..2", hi_min, hi_max); end
      n_vec++; if ((lo_min != 2) || (lo_max != 2)) begin n_err++; $display("FAIL fast_low_phase got=%0d..%0d exp=2..2", lo_min, lo_max); end
   endtask

   initial begin
      reset      = 1'b1;
      reset2     = 1'b1;
      bus.start  = 1'b0;
      bus.irq_n  = 1'b1;
      bus2.start = 1'b0;
      bus2.irq_n = 1'b1;
      test_reset();
      reset2 = 1'b0;
      test_good_frame();
      test_frame_table();
      test_irq();
      test_overrun();
      test_check_window();
      test_coincide();
      test_reset_mid();
      test_fast_timing();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
